// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-transfer arbiter.
//   - Default bus geometry (NUM_REGS / IDX_W)
//   - Transfer FSM state encoding
//   - onehot(): index -> one-hot register select, zero when out of range
package reg_xfer_pkg;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_IDX_W    = 4;

    // Widest register file onehot() can decode; callers size-cast the result
    // down to their own NUM_REGS.
    localparam int MAX_REGS = 256;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        DRIVE,
        WRITE,
        ACK
    } xfer_state_e;

    // An index at or beyond n (possible only when n is not a power of two)
    // selects no register at all.
    function automatic logic [MAX_REGS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n);
        onehot = '0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            onehot[i] = (idx == i) && (idx < n);
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req0, i_req1   request lines (0 = control unit, 1 = debug port)
//   i_update         commit the current winner into the last-grant pointer
//   o_grant          winner identity (0 or 1), valid while o_any is high
//   o_any            at least one request is pending
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_grant,
    output logic o_any
);

    logic r_last;

    // A lone request wins outright; under contention the requester that was
    // not served last wins.
    assign o_grant = i_req1 & (~i_req0 | ~r_last);
    assign o_any   = i_req0 | i_req1;

    // Pointer resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples pre-edge values regardless of block ordering.
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/reg_xfer_arbiter.sv
// Register-transfer bus arbiter: grants one of two requesters, then walks a
// fixed GRANT -> DRIVE -> WRITE -> ACK sequence that drives the source
// register onto the bus and loads it into the destination register.
// Ports:
//   clk, clr           clock, asynchronous active-low reset
//   req0/req1          transfer requests (0 = control unit, 1 = debug port)
//   src0/src1          source register index per requester
//   dst0/dst1          destination register index per requester
//   ba0/ba1            base-address mode (R0 reads as zero)
//   ack0/ack1          one-cycle transfer-complete pulse per requester
//   Rout               one-hot register bus-drive enable
//   Rin                one-hot register load enable
//   BAout              R0 zero-mask control
//   busy               high whenever the FSM is not IDLE
import reg_xfer_pkg::*;

module reg_xfer_arbiter #(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req0,
    input  logic                req1,
    input  logic [IDX_W-1:0]    src0,
    input  logic [IDX_W-1:0]    src1,
    input  logic [IDX_W-1:0]    dst0,
    input  logic [IDX_W-1:0]    dst1,
    input  logic                ba0,
    input  logic                ba1,
    output logic                ack0,
    output logic                ack1,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                BAout,
    output logic                busy
);

    xfer_state_e r_state;
    xfer_state_e w_next;

    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_dst;
    logic             r_ba;
    logic             r_id;

    logic [NUM_REGS-1:0] r_rout;
    logic [NUM_REGS-1:0] r_rin;
    logic                r_baout;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;

    logic                w_grant_id;
    logic                w_any_req;
    logic                w_start;
    logic                w_bus_phase;
    logic                w_ba_eff;
    logic [NUM_REGS-1:0] w_src_oh;
    logic [NUM_REGS-1:0] w_dst_oh;

    assign w_start = (r_state == IDLE) && w_any_req;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (clr),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_update (w_start),
        .o_grant  (w_grant_id),
        .o_any    (w_any_req)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: assigning the default before the case guarantees every path
        // writes w_next, so no latch is inferred.
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = GRANT;
            GRANT:   w_next = DRIVE;
            DRIVE:   w_next = WRITE;
            WRITE:   w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- Transfer context ----------------
    // Captured only when leaving IDLE; requester inputs are ignored for the
    // rest of the transfer, so a dropped req cannot abort it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_src <= '0;
            r_dst <= '0;
            r_ba  <= 1'b0;
            r_id  <= 1'b0;
        end else if (w_start) begin
            r_src <= w_grant_id ? src1 : src0;
            r_dst <= w_grant_id ? dst1 : dst0;
            r_ba  <= w_grant_id ? ba1  : ba0;
            r_id  <= w_grant_id;
        end
    end

    // ---------------- Registered outputs ----------------
    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state the FSM is actually in. The transfer context is
    // already valid whenever the next state is DRIVE or WRITE.
    assign w_src_oh    = NUM_REGS'(onehot(32'(r_src), $unsigned(NUM_REGS)));
    assign w_dst_oh    = NUM_REGS'(onehot(32'(r_dst), $unsigned(NUM_REGS)));
    assign w_bus_phase = (w_next == DRIVE) || (w_next == WRITE);
    // Base-address masking only applies when R0 is the source.
    assign w_ba_eff    = r_ba && (r_src == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rout  <= '0;
            r_rin   <= '0;
            r_baout <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rout  <= w_bus_phase ? w_src_oh : '0;
            r_rin   <= (w_next == WRITE) ? w_dst_oh : '0;
            r_baout <= w_bus_phase && w_ba_eff;
            r_ack0  <= (w_next == ACK) && !r_id;
            r_ack1  <= (w_next == ACK) &&  r_id;
            r_busy  <= (w_next != IDLE);
        end
    end

    assign Rout  = r_rout;
    assign Rin   = r_rin;
    assign BAout = r_baout;
    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign busy  = r_busy;

endmodule

// File: tb/tb_reg_xfer_arbiter.sv
// Directed testbench for reg_xfer_arbiter at default parameters.
// Outputs are packed as {busy, ack1, ack0, BAout, Rin, Rout} and compared
// one cycle at a time against hand-computed per-cycle expectations.
module tb_reg_xfer_arbiter;

    logic        clk;
    logic        clr;
    logic        req0, req1;
    logic [3:0]  src0, src1, dst0, dst1;
    logic        ba0, ba1;
    logic        ack0, ack1;
    logic [15:0] Rout, Rin;
    logic        BAout, busy;

    logic [35:0] obs;
    int          errors;
    int          checks;

    reg_xfer_arbiter dut (
        .clk   (clk),
        .clr   (clr),
        .req0  (req0),
        .req1  (req1),
        .src0  (src0),
        .src1  (src1),
        .dst0  (dst0),
        .dst1  (dst1),
        .ba0   (ba0),
        .ba1   (ba1),
        .ack0  (ack0),
        .ack1  (ack1),
        .Rout  (Rout),
        .Rin   (Rin),
        .BAout (BAout),
        .busy  (busy)
    );

    assign obs = {busy, ack1, ack0, BAout, Rin, Rout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack expected outputs in the same order as obs.
    function automatic logic [35:0] ev(input logic b, input logic a1,
                                       input logic a0, input logic ba,
                                       input logic [15:0] rin,
                                       input logic [15:0] rout);
        return {b, a1, a0, ba, rin, rout};
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1 clr = 1'b0;
        #1;
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL reset_async: got %h exp %h", obs, 36'h0);
        end
        req0 = 1'b1;
        step();
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL reset_held: got %h exp %h", obs, 36'h0);
        end
        req0 = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        step();
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h exp %h", obs, 36'h0);
        end
    endtask

    task automatic test_basic();
        logic [35:0] exp_v [5];
        exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
        exp_v[1] = ev(1, 0, 0, 0, 16'h0000, 16'h0008);
        exp_v[2] = ev(1, 0, 0, 0, 16'h0080, 16'h0008);
        exp_v[3] = ev(1, 0, 1, 0, 16'h0000, 16'h0000);
        exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
        req0 = 1'b1; src0 = 4'd3; dst0 = 4'd7; ba0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL basic[%0d]: got %h exp %h", c, obs, exp_v[c]);
            end
            if (c == 3) req0 = 1'b0;
        end
    endtask

    task automatic test_base_addr();
        logic [35:0] exp_v [5];
        exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
        exp_v[1] = ev(1, 0, 0, 1, 16'h0000, 16'h0001);
        exp_v[2] = ev(1, 0, 0, 1, 16'h0020, 16'h0001);
        exp_v[3] = ev(1, 1, 0, 0, 16'h0000, 16'h0000);
        exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
        req1 = 1'b1; src1 = 4'd0; dst1 = 4'd5; ba1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL base_addr[%0d]: got %h exp %h", c, obs, exp_v[c]);
            end
            if (c == 3) req1 = 1'b0;
        end
    endtask

    // Requester 1 was also served last; a lone request still wins.
    task automatic test_base_addr_ignored();
        logic [35:0] exp_v [5];
        exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
        exp_v[1] = ev(1, 0, 0, 0, 16'h0000, 16'h0004);
        exp_v[2] = ev(1, 0, 0, 0, 16'h0200, 16'h0004);
        exp_v[3] = ev(1, 1, 0, 0, 16'h0000, 16'h0000);
        exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
        req1 = 1'b1; src1 = 4'd2; dst1 = 4'd9; ba1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL ba_ignored[%0d]: got %h exp %h", c, obs, exp_v[c]);
            end
            if (c == 3) begin
                req1 = 1'b0;
                ba1  = 1'b0;
            end
        end
    endtask

    // Request dropped and inputs scrambled in DRIVE; src == dst.
    task automatic test_drop_same_reg();
        logic [35:0] exp_v [5];
        exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
        exp_v[1] = ev(1, 0, 0, 0, 16'h0000, 16'h0010);
        exp_v[2] = ev(1, 0, 0, 0, 16'h0010, 16'h0010);
        exp_v[3] = ev(1, 0, 1, 0, 16'h0000, 16'h0000);
        exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
        req0 = 1'b1; src0 = 4'd4; dst0 = 4'd4; ba0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL drop[%0d]: got %h exp %h", c, obs, exp_v[c]);
            end
            if (c == 1) begin
                req0 = 1'b0; src0 = 4'd9; dst0 = 4'd1; ba0 = 1'b1;
            end
        end
        ba0 = 1'b0;
    endtask

    // Reset mid-WRITE, then contention: the restored pointer must favour 0.
    task automatic test_reset_mid();
        logic [35:0] exp_v [5];
        req0 = 1'b1; src0 = 4'd5; dst0 = 4'd6; ba0 = 1'b0;
        step(); step(); step();
        checks++;
        if (obs !== ev(1, 0, 0, 0, 16'h0040, 16'h0020)) begin
            errors++;
            $display("FAIL rst_mid_write: got %h exp %h", obs,
                     ev(1, 0, 0, 0, 16'h0040, 16'h0020));
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h exp %h", obs, 36'h0);
        end
        step();
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL rst_mid_noack: got %h exp %h", obs, 36'h0);
        end
        @(negedge clk);
        clr  = 1'b1;
        req1 = 1'b1; src1 = 4'd11; dst1 = 4'd12; ba1 = 1'b0;
        exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
        exp_v[1] = ev(1, 0, 0, 0, 16'h0000, 16'h0020);
        exp_v[2] = ev(1, 0, 0, 0, 16'h0040, 16'h0020);
        exp_v[3] = ev(1, 0, 1, 0, 16'h0000, 16'h0000);
        exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL rst_restart[%0d]: got %h exp %h", c, obs, exp_v[c]);
            end
            if (c == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    // Both requests held high from reset: grants 0,1,0,1, one every 5 cycles.
    task automatic test_back_to_back();
        logic [35:0] exp_v [5];
        logic        w;
        step();
        clr = 1'b0;
        #2 clr = 1'b1;
        req0 = 1'b1; src0 = 4'd1; dst0 = 4'd2; ba0 = 1'b0;
        req1 = 1'b1; src1 = 4'd6; dst1 = 4'd8; ba1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = (k % 2 == 1);
            exp_v[0] = ev(1, 0, 0, 0, 16'h0000, 16'h0000);
            exp_v[1] = ev(1, 0, 0, 0, 16'h0000, w ? 16'h0040 : 16'h0002);
            exp_v[2] = ev(1, 0, 0, 0, w ? 16'h0100 : 16'h0004,
                          w ? 16'h0040 : 16'h0002);
            exp_v[3] = ev(1, w, !w, 0, 16'h0000, 16'h0000);
            exp_v[4] = ev(0, 0, 0, 0, 16'h0000, 16'h0000);
            for (int c = 0; c < 5; c++) begin
                step();
                checks++;
                if (obs !== exp_v[c]) begin
                    errors++;
                    $display("FAIL b2b[%0d][%0d]: got %h exp %h", k, c, obs, exp_v[c]);
                end
                if (k == 3 && c == 3) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        step();
        checks++;
        if (obs !== 36'h0) begin
            errors++;
            $display("FAIL b2b_quiet: got %h exp %h", obs, 36'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        req0 = 1'b0; req1 = 1'b0;
        src0 = '0; src1 = '0; dst0 = '0; dst1 = '0;
        ba0 = 1'b0; ba1 = 1'b0;
        test_reset();
        test_basic();
        test_base_addr();
        test_base_addr_ignored();
        test_drop_same_reg();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
